rgb2stream: RTL and testbench
=============================

Name: rgb2stream

Overview:
- Converts parallel RGB video timing (HSYNC/VSYNC/VDE/DATA) into an AXI4-Stream video master: tuser marks the first pixel of a frame, tlast marks the last pixel of a line.
- Capture-side counterpart of the stream-to-RGB output path, for camera/HDMI-receiver inputs feeding VDMA or processing pipelines.
- Pixel clock and AXI clock are the same clock (aclk).
- An internal FIFO absorbs downstream backpressure. An overflow drops the rest of the frame, and the block resynchronises on the next VSYNC.

Parameters:
- DATA_W, 24, pixel width in bits.
- ACTIVE_W, 1920, expected active pixels per line; used only for error checking.
- ACTIVE_H, 1080, expected active lines per frame; used only for error checking.
- FIFO_DEPTH, 2048, FIFO entries; must be a power of 2.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- rgb_HSYNC  in  1  horizontal sync; accepted but unused
- rgb_VSYNC  in  1  vertical sync, active-high
- rgb_VDE  in  1  data enable, active-high
- rgb_DATA  in  DATA_W  pixel
- axis_m_tvalid  out  1  stream valid
- axis_m_tready  in  1  stream ready
- axis_m_tuser  out  1  start of frame
- axis_m_tlast  out  1  end of line
- axis_m_tdata  out  DATA_W  pixel
- overflow  out  1  sticky; a pixel was dropped because the FIFO was full
- len_err  out  1  sticky; a line or frame length mismatch occurred
- in_sync  out  1  high when the FSM is in ARMED or ACTIVE

Behaviour:
- Reset: aresetn is synchronous, active-low; clock is aclk.
  - On reset: FIFO flushed; FSM enters IDLE; all input registers cleared.
  - All outputs 0: axis_m_tvalid, axis_m_tuser, axis_m_tlast, axis_m_tdata, overflow, len_err, in_sync.
  - Reset mid-frame: tvalid drops to 0 the cycle after reset is sampled; the block waits for a new VSYNC rising edge.
- Input stage: rgb_VSYNC, rgb_VDE and rgb_DATA are registered every cycle into vs_q, de_q and d_q.
  - vs_rise = rgb_VSYNC & !vs_q.
  - Pixel candidate = de_q. Its tlast = de_q & !rgb_VDE, i.e. the last pixel of each VDE run.
- FSM, all transitions on aclk:
  - IDLE: all pixels discarded. vs_rise -> ARMED.
  - ARMED: first de_q pixel is written with tuser=1 -> ACTIVE. vs_rise stays in ARMED.
  - ACTIVE: every de_q pixel is written with tuser=0. vs_rise -> ARMED.
  - DROP: all pixels discarded. vs_rise -> ARMED.
  - Any state: a de_q pixel arriving while the FIFO is full is not written; overflow <= 1; state -> DROP. This includes the tuser pixel in ARMED.
- Same-cycle vs_rise and de_q pixel: the pixel is handled under the current state's rules first, then the transition is taken.
- FIFO: synchronous, first-word-fall-through, entry = {tuser, tlast, data}.
  - axis_m_tvalid = !empty. tuser, tlast and tdata come from the head entry.
  - Pop when tvalid & tready. The head is held stable while tready=0.
  - Simultaneous push and pop on a full FIFO: the push is refused (full is evaluated before the pop).
  - Data already in the FIFO at overflow is still delivered: downstream sees a truncated frame, and the next frame begins with tuser.
- Latency: a pixel sampled at edge n is in the input register after edge n; it is written to the FIFO at edge n+1; tvalid is high after edge n+1 when the FIFO was empty.
- Length checks, in ACTIVE/ARMED only:
  - 12-bit pixel counter, cleared after each tlast pixel. At a tlast pixel, if count+1 != ACTIVE_W then len_err <= 1.
  - 11-bit line counter, incremented per tlast pixel and cleared on vs_rise. On vs_rise in ACTIVE, if lines != ACTIVE_H then len_err <= 1.
  - Counters saturate and do not wrap.
- overflow and len_err clear only on reset.

Decomposition:
- Shared package video_pkg: DATA_W, 1080p default constants (ACTIVE_W, ACTIVE_H), the FSM state encoding (IDLE, ARMED, ACTIVE, DROP), and the FIFO entry width (DATA_W+2).
- One sub-module: sync_fifo_fwft. Parameters: width and depth. Ports: clk, srst, din, wr_en, rd_en, dout, full, empty.
- rgb2stream contains the input stage, FSM, counters and flags.

Test Plan:
- Frame passthrough (ACTIVE_W=8, ACTIVE_H=4, tready=1). One VSYNC pulse, then 4 lines of 8 pixels with data = line*8+col, 4 blanking cycles between lines -> 32 beats; tuser only on beat 0; tlast on beats 7, 15, 23, 31; data 0..31 in order; overflow=0, len_err=0.
- Pre-sync discard. A VDE run of 8 pixels before any VSYNC -> no tvalid, in_sync=0. Then VSYNC and a frame -> only that frame is output, with tuser on its first pixel.
- Overflow (FIFO_DEPTH=16, tready=0). Send a full frame -> 16 beats held and overflow=1. Then tready=1, VSYNC, second frame -> 16 old beats, then the full second frame starting with tuser; overflow stays 1.
- Short line. Line 2 has 6 pixels -> tlast on its 6th pixel; len_err=1 after that pixel; all other tlast positions unchanged.
- Reset mid-frame. Assert aresetn=0 for 1 cycle after pixel 10 -> tvalid=0 the following cycle; remaining pixels of the frame ignored; next VSYNC frame delivered complete with tuser.
- Random backpressure. tready random at 50% over 3 frames, with 8 blanking cycles per line -> no overflow; beat order and data exact; tuser count 3; tlast count 12.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video constants, FSM state encoding and FIFO entry sizing for the RGB capture path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package video_pkg;

  localparam int VID_DATA_W   = 24;
  localparam int VID_ACTIVE_W = 1920;
  localparam int VID_ACTIVE_H = 1080;
  // FIFO entry is {tuser, tlast, data}
  localparam int VID_ENTRY_W  = VID_DATA_W + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DROP   = 2'd3
  } state_t;

  function automatic int entry_w(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head entry is visible on dout whenever not empty.
// Latency: a write at edge n is visible on dout after edge n when the FIFO was empty.
// Backpressure: writes are refused while full (full is taken before any same-cycle read).
module sync_fifo_fwft #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             push, pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;
  // Drive zero while empty so the stream outputs are clean after reset
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // Storage array: written only on accepted pushes, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rgb2stream.sv
// Parallel RGB timing (VSYNC/VDE/DATA) to AXI4-Stream video master with tuser=SOF and tlast=EOL.
// Latency: pixel sampled at edge n is written at edge n+1; tvalid high after edge n+1 if FIFO was empty.
// Backpressure: FIFO absorbs tready stalls; on FIFO full the rest of the frame is dropped until VSYNC.
module rgb2stream
  import video_pkg::*;
#(
  parameter int DATA_W     = VID_DATA_W,
  parameter int ACTIVE_W   = VID_ACTIVE_W,
  parameter int ACTIVE_H   = VID_ACTIVE_H,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              rgb_HSYNC,
  input  logic              rgb_VSYNC,
  input  logic              rgb_VDE,
  input  logic [DATA_W-1:0] rgb_DATA,
  output logic              axis_m_tvalid,
  input  logic              axis_m_tready,
  output logic              axis_m_tuser,
  output logic              axis_m_tlast,
  output logic [DATA_W-1:0] axis_m_tdata,
  output logic              overflow,
  output logic              len_err,
  output logic              in_sync
);

  localparam int EW = entry_w(DATA_W);

  logic              vs_q, de_q;
  logic [DATA_W-1:0] d_q;
  state_t            state_q, state_d;
  logic [11:0]       pix_cnt_q;
  logic [10:0]       line_cnt_q, line_nxt;
  logic              overflow_q, len_err_q;

  logic              vs_rise, pix_last, capture, sof;
  logic              wr_req, wr_en, drop_ovf;
  logic              fifo_full, fifo_empty;
  logic [EW-1:0]     fifo_dout;
  logic              unused_hsync;

  // HSYNC carries no information beyond VDE here
  assign unused_hsync = rgb_HSYNC;

  assign vs_rise  = rgb_VSYNC & ~vs_q;
  assign pix_last = de_q & ~rgb_VDE;
  assign wr_req   = de_q & capture;
  assign wr_en    = wr_req & ~fifo_full;
  assign drop_ovf = wr_req & fifo_full;

  // Input stage: register timing and data every cycle
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
      d_q  <= '0;
    end else begin
      vs_q <= rgb_VSYNC;
      de_q <= rgb_VDE;
      d_q  <= rgb_DATA;
    end
  end

  // FSM state register
  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: current pixel is handled first, then overflow, then VSYNC re-arm
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED:   if (wr_en) state_d = ACTIVE;
      default: state_d = state_q;
    endcase
    if (drop_ovf) state_d = DROP;
    if (vs_rise)  state_d = ARMED;
  end

  // FSM outputs: capture window and start-of-frame marker
  always_comb begin
    capture = (state_q == ARMED) || (state_q == ACTIVE);
    sof     = (state_q == ARMED);
  end

  // Line count including a line ending on this cycle, saturating
  always_comb begin
    line_nxt = line_cnt_q;
    if (wr_req && pix_last && (line_cnt_q != '1)) line_nxt = line_cnt_q + 1'b1;
  end

  // Length counters and sticky error flags
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      overflow_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      if (drop_ovf) overflow_q <= 1'b1;
      if (wr_req) begin
        if (pix_last) begin
          pix_cnt_q <= '0;
          if (({1'b0, pix_cnt_q} + 13'd1) != 13'(ACTIVE_W)) len_err_q <= 1'b1;
        end else if (pix_cnt_q != '1) begin
          pix_cnt_q <= pix_cnt_q + 1'b1;
        end
      end
      line_cnt_q <= line_nxt;
      if (vs_rise) begin
        if ((state_q == ACTIVE) && (line_nxt != 11'(ACTIVE_H))) len_err_q <= 1'b1;
        line_cnt_q <= '0;
        // Restart the pixel count so a truncated frame cannot skew the next one
        pix_cnt_q  <= '0;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .srst  (~aresetn),
    .din   ({sof, pix_last, d_q}),
    .wr_en (wr_en),
    .rd_en (axis_m_tready & ~fifo_empty),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign axis_m_tvalid = ~fifo_empty;
  assign {axis_m_tuser, axis_m_tlast, axis_m_tdata} = fifo_dout;
  assign overflow      = overflow_q;
  assign len_err       = len_err_q;
  assign in_sync       = capture;

endmodule

// File: tb/tb_rgb2stream.sv
// Bench for rgb2stream: small-FIFO instance for directed cases, large-FIFO instance for random backpressure.
// Latency: expected beats are derived from frame descriptions, not cycle timing.
// Backpressure: tready driven directly or at random per cycle.
module tb_rgb2stream;

  logic        aclk, aresetn;
  logic        hs, vs, de, tready;
  logic [23:0] dat;

  logic        s_tvalid, s_tuser, s_tlast, s_ovf, s_lerr, s_sync;
  logic [23:0] s_tdata;
  logic        b_tvalid, b_tuser, b_tlast, b_ovf, b_lerr, b_sync;
  logic [23:0] b_tdata;

  logic [25:0] s_q[$];
  logic [25:0] b_q[$];
  logic [25:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_rdy = 0;

  rgb2stream #(.DATA_W(24), .ACTIVE_W(8), .ACTIVE_H(4), .FIFO_DEPTH(16)) dut_s (
    .aclk(aclk), .aresetn(aresetn), .rgb_HSYNC(hs), .rgb_VSYNC(vs), .rgb_VDE(de), .rgb_DATA(dat),
    .axis_m_tvalid(s_tvalid), .axis_m_tready(tready), .axis_m_tuser(s_tuser), .axis_m_tlast(s_tlast),
    .axis_m_tdata(s_tdata), .overflow(s_ovf), .len_err(s_lerr), .in_sync(s_sync));

  rgb2stream #(.DATA_W(24), .ACTIVE_W(8), .ACTIVE_H(4), .FIFO_DEPTH(2048)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .rgb_HSYNC(hs), .rgb_VSYNC(vs), .rgb_VDE(de), .rgb_DATA(dat),
    .axis_m_tvalid(b_tvalid), .axis_m_tready(tready), .axis_m_tuser(b_tuser), .axis_m_tlast(b_tlast),
    .axis_m_tdata(b_tdata), .overflow(b_ovf), .len_err(b_lerr), .in_sync(b_sync));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Beat collectors: a beat seen with valid&ready at the negedge is consumed at the next posedge
  always @(negedge aclk) begin
    if (s_tvalid && tready) s_q.push_back({s_tuser, s_tlast, s_tdata});
    if (b_tvalid && tready) b_q.push_back({b_tuser, b_tlast, b_tdata});
  end

  task automatic cyc(input logic v, input logic d, input logic [23:0] x);
    vs  = v;
    de  = d;
    hs  = ~d;
    dat = x;
    if (rand_rdy) tready = 1'($urandom_range(0, 1));
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    aresetn = 1'b1;
    cyc(0, 0, 0);
    s_q.delete();
    b_q.delete();
    exp_q.delete();
  endtask

  task automatic vsync_pulse();
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
  endtask

  task automatic send_line(input int base, input int l, input int w, input int blank);
    for (int c = 0; c < w; c++) cyc(0, 1, 24'(base + l * 8 + c));
    for (int b = 0; b < blank; b++) cyc(0, 0, 0);
  endtask

  task automatic send_frame(input int base, input int nlines, input int blank);
    vsync_pulse();
    for (int l = 0; l < nlines; l++) send_line(base, l, 8, blank);
  endtask

  // Reference: a frame of 8-pixel lines (one optionally shortened), first pixel tuser, last of line tlast
  task automatic exp_frame(input int base, input int nlines, input int short_l, input int short_w,
                           input int limit);
    int n;
    int w;
    n = 0;
    for (int l = 0; l < nlines; l++) begin
      w = (l == short_l) ? short_w : 8;
      for (int c = 0; c < w; c++) begin
        if (n < limit) exp_q.push_back({(n == 0), (c == w - 1), 24'(base + l * 8 + c)});
        n++;
      end
    end
  endtask

  task automatic wait_q(input int n, input bit big);
    int i;
    i = 0;
    while (((big ? b_q.size() : s_q.size()) < n) && (i < 3000)) begin
      cyc(0, 0, 0);
      i++;
    end
    repeat (20) cyc(0, 0, 0);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tready  = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    n_checks++; if (s_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b expected 0", s_tvalid); else n_pass++;
    n_checks++; if (s_tuser !== 1'b0) $display("FAIL rst_tuser: got %b expected 0", s_tuser); else n_pass++;
    n_checks++; if (s_tlast !== 1'b0) $display("FAIL rst_tlast: got %b expected 0", s_tlast); else n_pass++;
    n_checks++; if (s_tdata !== 24'h0) $display("FAIL rst_tdata: got %h expected 0", s_tdata); else n_pass++;
    n_checks++; if (s_ovf !== 1'b0) $display("FAIL rst_overflow: got %b expected 0", s_ovf); else n_pass++;
    n_checks++; if (s_lerr !== 1'b0) $display("FAIL rst_len_err: got %b expected 0", s_lerr); else n_pass++;
    n_checks++; if (s_sync !== 1'b0) $display("FAIL rst_in_sync: got %b expected 0", s_sync); else n_pass++;
    do_reset();
  endtask

  task automatic test_latency();
    do_reset();
    tready = 1'b0;
    vsync_pulse();
    n_checks++; if (s_sync !== 1'b1) $display("FAIL lat_in_sync: got %b expected 1", s_sync); else n_pass++;
    cyc(0, 1, 24'h5A5A5A);
    n_checks++; if (s_tvalid !== 1'b0) $display("FAIL lat_edge_n: got tvalid %b expected 0", s_tvalid); else n_pass++;
    cyc(0, 0, 0);
    n_checks++; if (s_tvalid !== 1'b1) $display("FAIL lat_edge_n1: got tvalid %b expected 1", s_tvalid); else n_pass++;
    n_checks++;
    if ({s_tuser, s_tlast, s_tdata} !== {1'b1, 1'b1, 24'h5A5A5A})
      $display("FAIL lat_head: got %h expected %h", {s_tuser, s_tlast, s_tdata}, {2'b11, 24'h5A5A5A});
    else n_pass++;
  endtask

  task automatic test_passthrough();
    do_reset();
    tready = 1'b1;
    send_frame(0, 4, 4);
    exp_frame(0, 4, -1, 8, 1000);
    wait_q(exp_q.size(), 0);
    vsync_pulse();
    n_checks++;
    if (s_q.size() !== exp_q.size()) $display("FAIL pass_count: got %0d expected %0d", s_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < s_q.size(); i++) begin
      n_checks++;
      if (s_q[i] !== exp_q[i]) $display("FAIL pass_beat%0d: got %h expected %h", i, s_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (s_ovf !== 1'b0) $display("FAIL pass_overflow: got %b expected 0", s_ovf); else n_pass++;
    n_checks++; if (s_lerr !== 1'b0) $display("FAIL pass_len_err: got %b expected 0", s_lerr); else n_pass++;
  endtask

  task automatic test_presync();
    do_reset();
    tready = 1'b1;
    send_line(500, 0, 8, 6);
    n_checks++; if (s_tvalid !== 1'b0) $display("FAIL presync_tvalid: got %b expected 0", s_tvalid); else n_pass++;
    n_checks++; if (s_sync !== 1'b0) $display("FAIL presync_in_sync: got %b expected 0", s_sync); else n_pass++;
    n_checks++; if (s_q.size() !== 0) $display("FAIL presync_beats: got %0d expected 0", s_q.size()); else n_pass++;
    send_frame(64, 4, 4);
    n_checks++; if (s_sync !== 1'b1) $display("FAIL presync_in_sync_after: got %b expected 1", s_sync); else n_pass++;
    exp_frame(64, 4, -1, 8, 1000);
    wait_q(exp_q.size(), 0);
    n_checks++;
    if (s_q.size() !== exp_q.size()) $display("FAIL presync_count: got %0d expected %0d", s_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < s_q.size(); i++) begin
      n_checks++;
      if (s_q[i] !== exp_q[i]) $display("FAIL presync_beat%0d: got %h expected %h", i, s_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    tready = 1'b0;
    send_frame(0, 4, 4);
    n_checks++; if (s_ovf !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", s_ovf); else n_pass++;
    n_checks++; if (s_tvalid !== 1'b1) $display("FAIL ovf_held: got tvalid %b expected 1", s_tvalid); else n_pass++;
    n_checks++; if (s_sync !== 1'b0) $display("FAIL ovf_in_sync: got %b expected 0", s_sync); else n_pass++;
    exp_frame(0, 4, -1, 8, 16);
    tready = 1'b1;
    send_frame(100, 4, 4);
    exp_frame(100, 4, -1, 8, 1000);
    wait_q(exp_q.size(), 0);
    n_checks++;
    if (s_q.size() !== exp_q.size()) $display("FAIL ovf_count: got %0d expected %0d", s_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < s_q.size(); i++) begin
      n_checks++;
      if (s_q[i] !== exp_q[i]) $display("FAIL ovf_beat%0d: got %h expected %h", i, s_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (s_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", s_ovf); else n_pass++;
  endtask

  task automatic test_short_line();
    do_reset();
    tready = 1'b1;
    vsync_pulse();
    send_line(0, 0, 8, 4);
    send_line(0, 1, 8, 4);
    n_checks++; if (s_lerr !== 1'b0) $display("FAIL short_before: got len_err %b expected 0", s_lerr); else n_pass++;
    send_line(0, 2, 6, 4);
    n_checks++; if (s_lerr !== 1'b1) $display("FAIL short_after: got len_err %b expected 1", s_lerr); else n_pass++;
    send_line(0, 3, 8, 4);
    exp_frame(0, 4, 2, 6, 1000);
    wait_q(exp_q.size(), 0);
    n_checks++;
    if (s_q.size() !== exp_q.size()) $display("FAIL short_count: got %0d expected %0d", s_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < s_q.size(); i++) begin
      n_checks++;
      if (s_q[i] !== exp_q[i]) $display("FAIL short_beat%0d: got %h expected %h", i, s_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_short_frame();
    do_reset();
    tready = 1'b1;
    send_frame(0, 3, 4);
    n_checks++; if (s_lerr !== 1'b0) $display("FAIL sframe_before: got len_err %b expected 0", s_lerr); else n_pass++;
    vsync_pulse();
    n_checks++; if (s_lerr !== 1'b1) $display("FAIL sframe_after: got len_err %b expected 1", s_lerr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    tready = 1'b0;
    vsync_pulse();
    send_line(0, 0, 8, 4);
    for (int c = 0; c < 3; c++) cyc(0, 1, 24'(8 + c));
    aresetn = 1'b0;
    cyc(0, 1, 24'd11);
    aresetn = 1'b1;
    n_checks++; if (s_tvalid !== 1'b0) $display("FAIL rmid_tvalid: got %b expected 0", s_tvalid); else n_pass++;
    n_checks++; if (s_sync !== 1'b0) $display("FAIL rmid_in_sync: got %b expected 0", s_sync); else n_pass++;
    for (int c = 12; c < 16; c++) cyc(0, 1, 24'(c));
    cyc(0, 0, 0);
    send_line(0, 2, 8, 4);
    send_line(0, 3, 8, 4);
    tready = 1'b1;
    repeat (10) cyc(0, 0, 0);
    n_checks++; if (s_q.size() !== 0) $display("FAIL rmid_ignored: got %0d beats expected 0", s_q.size()); else n_pass++;
    send_frame(200, 4, 4);
    exp_frame(200, 4, -1, 8, 1000);
    wait_q(exp_q.size(), 0);
    n_checks++;
    if (s_q.size() !== exp_q.size()) $display("FAIL rmid_count: got %0d expected %0d", s_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < s_q.size(); i++) begin
      n_checks++;
      if (s_q[i] !== exp_q[i]) $display("FAIL rmid_beat%0d: got %h expected %h", i, s_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int nu, nl;
    do_reset();
    rand_rdy = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_frame(f * 40, 4, 8);
      exp_frame(f * 40, 4, -1, 8, 1000);
    end
    rand_rdy = 1'b0;
    tready = 1'b1;
    wait_q(exp_q.size(), 1);
    n_checks++; if (b_ovf !== 1'b0) $display("FAIL rand_overflow: got %b expected 0", b_ovf); else n_pass++;
    n_checks++;
    if (b_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d expected %0d", b_q.size(), exp_q.size());
    else n_pass++;
    nu = 0;
    nl = 0;
    for (int i = 0; i < b_q.size(); i++) begin
      nu += int'(b_q[i][25]);
      nl += int'(b_q[i][24]);
    end
    for (int i = 0; i < exp_q.size() && i < b_q.size(); i++) begin
      n_checks++;
      if (b_q[i] !== exp_q[i]) $display("FAIL rand_beat%0d: got %h expected %h", i, b_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (nu !== 3) $display("FAIL rand_tuser_count: got %0d expected 3", nu); else n_pass++;
    n_checks++; if (nl !== 12) $display("FAIL rand_tlast_count: got %0d expected 12", nl); else n_pass++;
  endtask

  initial begin
    aresetn = 1'b0;
    vs = 1'b0; de = 1'b0; hs = 1'b1; dat = '0;
    tready = 1'b0;
    test_reset();
    test_latency();
    test_passthrough();
    test_presync();
    test_overflow();
    test_short_line();
    test_short_frame();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
